// File: rtl/sampframe_pkg.sv
// Shared types and constants for the sample-frame packetizer.
package sampframe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    LEN,
    FETCH,
    DATA,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7e;
  localparam int         HDR_LEN      = 3;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction

endpackage

// File: rtl/sampframe_tx_if.sv
// Handshake bundles: the sample stream (avail/pull) and the host byte link.
interface samp_stream_if;
  logic [31:0] data;
  logic [7:0]  count;
  logic        avail;
  logic        pull;

  modport master (output data, count, avail, input pull);
  modport slave  (input data, count, avail, output pull);
endinterface

interface byte_link_if;
  logic [7:0] data;
  logic       avail;
  logic       pull;

  modport master (output data, avail, input pull);
  modport slave  (input data, avail, output pull);
endinterface

// File: rtl/sampframe_tx.sv
// Pulls 32-bit samples and emits framed packets:
// sync, seq, N, N*4 little-endian data bytes, XOR checksum (sync excluded).
module sampframe_tx
  import sampframe_pkg::*;
#(
  parameter int         MAX_BATCH = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  samp_stream_if.slave         samp_stream,
  byte_link_if.master          tx,
  output logic                 busy,
  output logic [15:0]          pkt_count
);

  localparam logic [7:0] MAX_N = MAX_BATCH[7:0];

  state_t      state;
  logic [7:0]  seq;
  logic [7:0]  len;
  logic [7:0]  remaining;
  logic [1:0]  idx;
  logic [31:0] word;
  logic [7:0]  csum;
  logic [7:0]  start_len;
  logic        accept;

  assign start_len        = (samp_stream.count > MAX_N) ? MAX_N : samp_stream.count;
  assign accept           = tx.avail && tx.pull;
  assign samp_stream.pull = (state == FETCH) && samp_stream.avail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      seq       <= '0;
      len       <= '0;
      remaining <= '0;
      idx       <= '0;
      word      <= '0;
      csum      <= '0;
      tx.data   <= '0;
      tx.avail  <= 1'b0;
      busy      <= 1'b0;
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && samp_stream.avail && samp_stream.count != 8'd0) begin
            len      <= start_len;
            csum     <= seq ^ start_len;
            tx.data  <= SYNC_BYTE;
            tx.avail <= 1'b1;
            busy     <= 1'b1;
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (accept) begin
            tx.data <= seq;
            state   <= SEQ;
          end
        end
        SEQ: begin
          if (accept) begin
            tx.data   <= len;
            remaining <= len;
            state     <= LEN;
          end
        end
        LEN: begin
          if (accept) begin
            tx.avail <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (samp_stream.avail) begin
            word      <= samp_stream.data;
            remaining <= remaining - 8'd1;
            idx       <= 2'd0;
            tx.data   <= samp_stream.data[7:0];
            tx.avail  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            csum <= csum ^ tx.data;
            if (idx == 2'd3) begin
              if (remaining != 8'd0) begin
                tx.avail <= 1'b0;
                state    <= FETCH;
              end else begin
                // last data byte folds into the checksum presented next
                tx.data <= csum ^ tx.data;
                state   <= CSUM;
              end
            end else begin
              idx     <= idx + 2'd1;
              tx.data <= word_byte(word, idx + 2'd1);
            end
          end
        end
        CSUM: begin
          if (accept) begin
            tx.avail  <= 1'b0;
            busy      <= 1'b0;
            seq       <= seq + 8'd1;
            pkt_count <= pkt_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          tx.avail <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sampframe_tx.sv
// Directed bench for sampframe_tx: sample-queue source model, byte scoreboard.
module tb_sampframe_tx;
  import sampframe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic busy;
  logic [15:0] pkt_count;

  samp_stream_if ss ();
  byte_link_if   bl ();

  sampframe_tx #(.MAX_BATCH(16), .SYNC_BYTE(8'h7e)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .samp_stream(ss),
    .tx(bl),
    .busy(busy),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] src[$];
  logic [31:0] staged[$];
  logic [7:0]  expq[$];
  logic [7:0]  tb_seq = 8'd0;

  bit  gate = 1'b1;
  bit  bp   = 1'b0;
  bit  pull_pend = 1'b0;
  bit  hold_prev = 1'b0;
  logic [7:0] hold_data = 8'd0;
  int  pulls = 0;
  int  xfer_cnt = 0;
  int  cyc = 0;
  int  last_pull = -100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic stage(input logic [31:0] d);
    src.push_back(d);
    staged.push_back(d);
  endtask

  task automatic expect_packet(input int n);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;
    cs = tb_seq ^ 8'(n);
    expq.push_back(SYNC_DEFAULT);
    expq.push_back(tb_seq);
    expq.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = staged.pop_front();
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        expq.push_back(b);
        cs = cs ^ b;
      end
    end
    expq.push_back(cs);
    tb_seq = tb_seq + 8'd1;
  endtask

  task automatic expect_all();
    while (staged.size() > 0)
      expect_packet(staged.size() > 16 ? 16 : staged.size());
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (expq.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, 32'(ok), 32'd1);
  endtask

  // source / sink model: inputs change only on negedges
  always @(negedge clk) begin
    logic [7:0] e;
    cyc++;
    if (pull_pend && src.size() > 0) void'(src.pop_front());
    ss.avail = gate && (src.size() != 0);
    ss.data  = (src.size() != 0) ? src[0] : 32'd0;
    ss.count = (src.size() > 255) ? 8'd255 : 8'(src.size());
    bl.pull  = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    #1;
    if (hold_prev) begin
      check("hold_avail", 32'(bl.avail), 32'd1);
      check("hold_data", 32'(bl.data), 32'(hold_data));
    end
    hold_prev = bl.avail && !bl.pull;
    hold_data = bl.data;
    if (bl.avail && bl.pull) begin
      xfer_cnt++;
      if (expq.size() == 0) check("extra_byte", 32'd1, 32'd0);
      else begin
        e = expq.pop_front();
        check("byte", 32'(bl.data), 32'(e));
      end
    end
    pull_pend = ss.pull;
    if (pull_pend) begin
      pulls++;
      check("pull_needs_avail", 32'(ss.avail), 32'd1);
      check("pull_gap_ge5", 32'((cyc - last_pull) >= 5), 32'd1);
      last_pull = cyc;
    end
  end

  initial begin
    int base;
    rst    = 1'b1;
    enable = 1'b0;
    ss.avail = 1'b0;
    ss.data  = 32'd0;
    ss.count = 8'd0;
    bl.pull  = 1'b1;
    step(2);
    check("rst_tx_avail", 32'(bl.avail), 32'd0);
    check("rst_tx_data", 32'(bl.data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_pull", 32'(ss.pull), 32'd0);
    rst = 1'b0;
    step(2);

    // disabled: samples waiting but nothing starts
    for (int i = 0; i < 5; i++) src.push_back(32'hdead0000 + 32'(i));
    step(30);
    check("dis_pulls", 32'(pulls), 32'd0);
    check("dis_tx_avail", 32'(bl.avail), 32'd0);
    check("dis_busy", 32'(busy), 32'd0);
    src.delete();
    step(2);

    // basic 3-sample packet
    stage(32'h11223344);
    stage(32'h55667788);
    stage(32'h99aabbcc);
    expect_all();
    enable = 1'b1;
    wait_done("basic", 200);
    check("basic_pulls", 32'(pulls), 32'd3);
    check("basic_pkt_count", 32'(pkt_count), 32'd1);

    // 40 samples split 16/16/8
    enable = 1'b0;
    base = pulls;
    for (int i = 0; i < 40; i++) stage($urandom);
    expect_all();
    enable = 1'b1;
    wait_done("batch", 2000);
    check("batch_pulls", 32'(pulls - base), 32'd40);
    check("batch_pkt_count", 32'(pkt_count), 32'd4);

    // backpressure on the byte link
    enable = 1'b0;
    bp = 1'b1;
    stage(32'h11223344);
    stage(32'h55667788);
    stage(32'h99aabbcc);
    expect_all();
    enable = 1'b1;
    wait_done("bp", 1000);
    check("bp_pkt_count", 32'(pkt_count), 32'd5);
    bp = 1'b0;

    // avail drops after the second pull
    enable = 1'b0;
    base = pulls;
    for (int i = 0; i < 4; i++) stage(32'ha5000000 + 32'(i * 32'h01010101));
    expect_all();
    enable = 1'b1;
    for (int i = 0; i < 200 && pulls < base + 2; i++) step(1);
    gate = 1'b0;
    step(20);
    check("stall_tx_avail", 32'(bl.avail), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_pulls", 32'(pulls - base), 32'd2);
    gate = 1'b1;
    wait_done("stall", 300);
    check("stall_pkt_count", 32'(pkt_count), 32'd6);

    // enable drops mid-packet: this one finishes, no next one
    enable = 1'b0;
    for (int i = 0; i < 20; i++) stage(32'h0badf00d ^ 32'(i));
    expect_packet(16);
    staged.delete();
    enable = 1'b1;
    for (int i = 0; i < 50 && !busy; i++) step(1);
    enable = 1'b0;
    wait_done("en_mid", 1000);
    step(30);
    check("en_mid_left", 32'(src.size()), 32'd4);
    check("en_mid_pkt_count", 32'(pkt_count), 32'd7);
    check("en_mid_busy", 32'(busy), 32'd0);
    src.delete();
    step(2);

    // reset while byte 2 of the second sample is presented
    for (int i = 0; i < 4; i++) stage(32'h10203040 + 32'(i));
    expect_all();
    base = xfer_cnt;
    enable = 1'b1;
    for (int i = 0; i < 300 && xfer_cnt < base + 10; i++) step(1);
    rst = 1'b1;
    #1;
    check("arst_tx_avail", 32'(bl.avail), 32'd0);
    check("arst_tx_data", 32'(bl.data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pkt_count", 32'(pkt_count), 32'd0);
    expq.delete();
    src.delete();
    staged.delete();
    tb_seq = 8'd0;
    step(2);
    rst = 1'b0;
    step(1);
    stage(32'hcafebabe);
    stage(32'h01234567);
    expect_all();
    wait_done("post_rst", 300);
    check("post_rst_pkt_count", 32'(pkt_count), 32'd1);
    check("sb_empty", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
